// File: rtl/preempt_irq_controller_pkg.sv
// Shared definitions for the preemption interrupt path: controller states and
// the fetch-side PC width and handler vector.
package preempt_irq_controller_pkg;

  localparam int DEFAULT_PC_W = 32;
  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HANDLER = 2'd2
  } irq_state_t;

endpackage

// File: rtl/preempt_irq_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/preempt_irq_controller.sv
// Latches quantum-timer sigint, dispatches to the handler at an enabled instruction
// boundary (take_irq one cycle after the boundary), and returns on rfi; all outputs registered.
module preempt_irq_controller
  import preempt_irq_controller_pkg::*;
#(
  parameter int              PC_W         = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(DEFAULT_HANDLER_ADDR),
  parameter int              MISS_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sigint,
  input  logic              irq_en_set,
  input  logic              irq_en_clr,
  input  logic              instr_boundary,
  input  logic [PC_W-1:0]   current_pc,
  input  logic              rfi,
  output logic              take_irq,
  output logic              rfi_redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   epc,
  output logic              timer_stop,
  output logic              timer_restart,
  output logic              irq_enabled,
  output logic              in_handler,
  output logic              irq_pending,
  output logic [MISS_W-1:0] missed_cnt
);

  irq_state_t state, state_nxt;
  logic       dispatch;
  logic       ret;
  logic       en_nxt;
  logic       en_rise_q;
  logic       miss_inc;

  always_comb begin
    state_nxt = state;
    dispatch  = 1'b0;
    ret       = 1'b0;
    case (state)
      IDLE: begin
        if (sigint) state_nxt = PENDING;
      end
      PENDING: begin
        if (irq_enabled && instr_boundary) begin
          dispatch  = 1'b1;
          state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (rfi) begin
          ret       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear beats set when both commit together.
  assign en_nxt   = irq_en_clr ? 1'b0 : (irq_en_set ? 1'b1 : irq_enabled);
  // Only an IDLE sigint can latch; any other sigint is dropped and counted.
  assign miss_inc = sigint && (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      take_irq      <= 1'b0;
      rfi_redirect  <= 1'b0;
      redirect_pc   <= '0;
      epc           <= '0;
      timer_stop    <= 1'b0;
      timer_restart <= 1'b0;
      irq_enabled   <= 1'b0;
      in_handler    <= 1'b0;
      irq_pending   <= 1'b0;
      en_rise_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      take_irq      <= dispatch;
      timer_stop    <= dispatch;
      rfi_redirect  <= ret;
      timer_restart <= ret || en_rise_q;
      en_rise_q     <= !irq_enabled && en_nxt;
      irq_enabled   <= en_nxt;
      irq_pending   <= (state_nxt == PENDING);
      in_handler    <= (state_nxt == HANDLER);
      if (dispatch) begin
        epc         <= current_pc;
        redirect_pc <= HANDLER_ADDR;
      end else if (ret) begin
        redirect_pc <= epc;
      end
    end
  end

  sat_counter #(.W(MISS_W)) u_missed (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (miss_inc),
    .count (missed_cnt)
  );

endmodule
